// File: rtl/div_iter_pkg.sv
// div_iter_pkg: shared state encodings and control constants for the iterative divider
package div_iter_pkg;
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
endpackage

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring signed/unsigned divider with annul and divide-by-zero flag
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               dbz_o
);
  div_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic nq_q, nq_d, nr_q, nr_d, ready_q, ready_d, dbz_q, dbz_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic a_neg, b_neg;
  logic [WIDTH:0] trial, diff;
  logic [WIDTH-1:0] quo_n, rem_n;
  assign a_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign b_neg = signed_div_i & opdata2_i[WIDTH-1];
  assign trial = {rem_q, quo_q[WIDTH-1]};
  assign diff  = trial - {1'b0, dvs_q};
  assign quo_n = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
  assign rem_n = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    nq_d     = nq_q;
    nr_d     = nr_q;
    result_d = result_q;
    ready_d  = ready_q;
    dbz_d    = dbz_q;
    case (state_q)
      DivFree: begin
        quo_d = a_neg ? -opdata1_i : opdata1_i;
        dvs_d = b_neg ? -opdata2_i : opdata2_i;
        rem_d = '0;
        nq_d  = a_neg ^ b_neg;
        nr_d  = a_neg;
        cnt_d = '0;
        if (start_i == DivStart && !annul_i)
          state_d = opdata2_i == '0 ? DivByZero : DivOn;
      end
      DivByZero: begin
        state_d  = DivEnd;
        result_d = '0;
        ready_d  = DivResultReady;
        dbz_d    = 1'b1;
      end
      DivOn: begin
        if (annul_i) state_d = DivFree;
        else begin
          quo_d = quo_n;
          rem_d = rem_n;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = DivEnd;
            ready_d  = DivResultReady;
            result_d = {nr_q ? -rem_n : rem_n, nq_q ? -quo_n : quo_n};
          end
        end
      end
      default: begin
        if (start_i == DivStop) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          dbz_d    = 1'b0;
          result_d = '0;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      nq_q     <= 1'b0;
      nr_q     <= 1'b0;
      result_q <= '0;
      ready_q  <= DivResultNotReady;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      nq_q     <= nq_d;
      nr_q     <= nr_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      dbz_q    <= dbz_d;
    end
  end
  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign dbz_o    = dbz_q;
  assign busy_o   = state_q == DivByZero || state_q == DivOn;
endmodule

// File: doc/div_iter.md
# div_iter

Parametrised iterative radix-2 integer divider for the pipeline's EX stage, successor to the fixed 32-bit divider. It accepts a signed or unsigned WIDTH-bit dividend/divisor pair from EX and produces quotient and remainder after WIDTH iteration cycles. It supports annulment mid-operation, early completion on a zero divisor with an explicit flag, and a `busy_o` status. EX holds its stall request until `ready_o` is seen.

## Interface
- `WIDTH`, 32, operand width in bits (≥4); iteration count equals WIDTH.
- `CNT_W`, $clog2(WIDTH)+1, iteration counter width.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `signed_div_i`  in  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
- `opdata1_i`  in  WIDTH  dividend; sampled with start.
- `opdata2_i`  in  WIDTH  divisor; sampled with start.
- `start_i`  in  1  request; level, held by EX until it consumes the result.
- `annul_i`  in  1  abort current operation (flush).
- `result_o`  out  2*WIDTH  {remainder, quotient}; valid only while `ready_o`=1.
- `ready_o`  out  1  result valid.
- `busy_o`  out  1  state is BY_ZERO or ON.
- `dbz_o`  out  1  divide-by-zero flag; valid only while `ready_o`=1.

## Operation
- States: FREE, BY_ZERO, ON, END.
- FREE:
  - `start_i`=1, `annul_i`=0, divisor≠0 → ON. Latch operands as magnitudes: negate a negative operand when signed. Latch sign info. Counter = 0.
  - Same, but divisor=0 → BY_ZERO.
  - Otherwise stay in FREE.
- BY_ZERO → END next edge. Result = 0, `dbz_o`=1.
- ON:
  - `annul_i`=1 → FREE; no result is produced.
  - Otherwise perform one restoring step per cycle: trial-subtract the divisor from the partial remainder, shift in the quotient bit, counter+1.
  - When counter reaches WIDTH → END. Apply sign fix-up:
    - quotient negated if signed and the operand signs differ;
    - remainder negated if signed and the dividend is negative.
- END:
  - `ready_o`=1; `result_o`/`dbz_o` held stable.
  - `start_i`=0 → FREE (result and flags cleared).
  - `start_i`=1 → stay in END; the result is held while EX is stalled.
- `annul_i` in END or FREE has no effect on the current state, except that in FREE it blocks acceptance of a start.
- Arithmetic rules:
  - quotient truncates toward zero; remainder = dividend − quotient×divisor.
  - Signed MIN / −1 → quotient = MIN, remainder = 0 (natural wrap; no trap).
  - Dividend 0 → quotient 0, remainder 0 after the full WIDTH cycles.
- Operands change while ON → ignored; only latched values are used.

## Timing
- Reset (`rst`=1 at an edge, in any state, including mid-ON): state FREE, counter 0, `result_o`=0, `ready_o`=0, `busy_o`=0, `dbz_o`=0.
- All outputs are registered.
- Start sampled at edge of cycle t:
  - ON spans cycles t+1 … t+WIDTH;
  - END (`ready_o`=1) first appears in cycle t+WIDTH+1.
- Divide by zero: BY_ZERO in t+1, END in t+2.
- `ready_o` drops the cycle after the first END-state edge that samples `start_i`=0.
- A new start is accepted no earlier than the cycle after `ready_o` drops: minimum one FREE cycle between operations.
- Annul sampled in ON at cycle t+k → FREE in cycle t+k+1; a start may be accepted at that FREE edge.

## Structure
- Shared defines file gains:
  - state encodings `DivFree`, `DivByZero`, `DivOn`, `DivEnd` (2 bits);
  - `DivResultReady`/`DivResultNotReady`;
  - `DivStart`/`DivStop`.
- Single module with no sub-module. The per-iteration trial subtract stays inline; it is one WIDTH+1-bit subtractor.
- The top level instantiates it in place of the old divider and wires `annul_i` to the flush signal (currently 0).

## Test plan
- Unsigned, WIDTH=32: 100 / 7 → in cycle t+33, `ready_o`=1 and `result_o`={32'd2, 32'd14}; `busy_o`=1 in t+1…t+32.
- Signed: −7 / 2 → quotient 32'hFFFFFFFD, remainder 32'hFFFFFFFF. Also 7 / −2 → quotient 32'hFFFFFFFD, remainder 32'd1.
- Signed 32'h80000000 / 32'hFFFFFFFF → quotient 32'h80000000, remainder 0. Unsigned 32'hFFFFFFFF / 1 → quotient 32'hFFFFFFFF, remainder 0.
- Divisor 0 (either mode) → `ready_o`=1 and `dbz_o`=1 in t+2, `result_o`=0.
- Annul at t+10 → `ready_o` never rises and `busy_o`=0 at t+11. A new start (50 / 5) at t+11 → `result_o`={0, 10} at t+44.
- Hold `start_i` for 5 cycles after ready → result stable throughout, then FREE. Assert `rst` at t+5 → all outputs 0 next cycle. Repeat with WIDTH=8: 200 / 3 → {8'd2, 8'd66} at t+9.
